// File: rtl/bp_be_fe_queue_buffer_pkg.sv
// Shared types for the BE-side FE queue buffer.
// Packet layout matches the default core configuration.
package bp_be_fe_queue_buffer_pkg;

    typedef enum logic {
        e_bp_default_cfg,
        e_bp_unicore_cfg
    } bp_params_e;

    typedef enum logic [1:0] {
        e_fe_fetch     = 2'd0,
        e_fe_exception = 2'd1
    } bp_fe_msg_e;

    localparam int vaddr_width_gp = 39;
    localparam int instr_width_gp = 32;
    localparam int bmeta_width_gp = 12;

    typedef struct packed {
        bp_fe_msg_e                msg_type;
        logic [vaddr_width_gp-1:0] pc;
        logic [instr_width_gp-1:0] instr;
        logic [bmeta_width_gp-1:0] branch_metadata;
    } bp_fe_queue_s;

endpackage

// File: rtl/bp_be_fe_queue_buffer_if.sv
// Valid/ready packet channel between FE, queue buffer and BE.
// rdy is ready_and on the enqueue side and yumi on the dequeue side.
interface bp_be_fe_queue_buffer_if;
    import bp_be_fe_queue_buffer_pkg::*;

    bp_fe_queue_s data;
    logic         v;
    logic         rdy;

    modport master (output data, output v, input rdy);
    modport slave  (input data, input v, output rdy);

endinterface

// File: rtl/bp_be_fe_queue_ptrs.sv
// Write/read/commit pointers with wrap bits, full/empty and
// the clear > roll > normal update priority.
module bp_be_fe_queue_ptrs #(
    parameter int els_p         = 8,
    localparam int ptr_width_lp = $clog2(els_p) + 1
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    enq_v_i,
    input  logic                    yumi_i,
    input  logic                    commit_i,
    input  logic                    roll_i,
    input  logic                    clr_i,
    output logic                    ready_and_o,
    output logic                    enq_o,
    output logic                    v_o,
    output logic                    empty_o,
    output logic [ptr_width_lp-2:0] waddr_o,
    output logic [ptr_width_lp-2:0] raddr_o
);

    localparam int msb_lp = ptr_width_lp - 1;

    typedef logic [ptr_width_lp-1:0] ptr_t;

    ptr_t wptr_q, wptr_d;
    ptr_t rptr_q, rptr_d;
    ptr_t cptr_q, cptr_d;
    ptr_t rptr_nxt;
    ptr_t cptr_inc;
    logic full;

    // Slots are reclaimed only by commit, so fullness is wptr vs cptr.
    assign full = (wptr_q[msb_lp-1:0] == cptr_q[msb_lp-1:0])
                & (wptr_q[msb_lp] != cptr_q[msb_lp]);

    assign ready_and_o = ~full & ~clr_i;
    assign enq_o       = enq_v_i & ready_and_o;
    assign v_o         = (rptr_q != wptr_q);
    assign empty_o     = ~v_o;
    assign waddr_o     = wptr_q[msb_lp-1:0];
    assign raddr_o     = rptr_q[msb_lp-1:0];

    assign rptr_nxt = rptr_q + ptr_t'(yumi_i);
    assign cptr_inc = cptr_q + ptr_t'(commit_i);

    always_comb begin
        wptr_d = wptr_q + ptr_t'(enq_o);
        rptr_d = rptr_nxt;
        cptr_d = cptr_inc;
        if (clr_i) begin
            rptr_d = wptr_q;
            cptr_d = wptr_q;
        end else if (roll_i) begin
            rptr_d = cptr_inc;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cptr_q <= cptr_d;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(yumi_i && !v_o))
                else $error("fe_queue: yumi without valid");
            assert (!(commit_i && !clr_i && !roll_i && cptr_q == rptr_nxt))
                else $error("fe_queue: commit with nothing dequeued");
        end
    end
`endif

endmodule

// File: rtl/bsg_mem_1r1w.sv
// One write port, one asynchronous read port register file.
// Contents are intentionally left unreset.
module bsg_mem_1r1w #(
    parameter int width_p                = 8,
    parameter int els_p                  = 8,
    parameter bit read_write_same_addr_p = 1'b0,
    localparam int addr_width_lp         = $clog2(els_p)
) (
    input  logic                     w_clk_i,
    input  logic                     w_v_i,
    input  logic [addr_width_lp-1:0] w_addr_i,
    input  logic [width_p-1:0]       w_data_i,
    input  logic                     r_v_i,
    input  logic [addr_width_lp-1:0] r_addr_i,
    output logic [width_p-1:0]       r_data_o
);

    logic [width_p-1:0] mem_q [els_p];

    always_ff @(posedge w_clk_i) begin
        if (w_v_i) begin
            mem_q[w_addr_i] <= w_data_i;
        end
    end

    assign r_data_o = mem_q[r_addr_i];

`ifndef SYNTHESIS
    always_ff @(posedge w_clk_i) begin
        if (!read_write_same_addr_p && w_v_i && r_v_i) begin
            assert (w_addr_i != r_addr_i)
                else $error("bsg_mem_1r1w: read/write same address");
        end
    end
`endif

endmodule

// File: rtl/bp_be_fe_queue_buffer.sv
// BE-side fetch queue: storage plus handshake glue around the
// speculative-dequeue pointer block.
module bp_be_fe_queue_buffer
    import bp_be_fe_queue_buffer_pkg::*;
#(
    parameter bp_params_e bp_params_p = e_bp_default_cfg,
    parameter int els_p               = 8,
    localparam int fe_queue_width_lp  = $bits(bp_fe_queue_s),
    localparam int ptr_width_lp       = $clog2(els_p) + 1
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    bp_be_fe_queue_buffer_if.slave    fe_in,
    bp_be_fe_queue_buffer_if.master   fe_out,
    input  logic                      commit_i,
    input  logic                      roll_i,
    input  logic                      clr_i,
    output logic                      empty_o
);

    logic                         enq;
    logic [ptr_width_lp-2:0]      waddr;
    logic [ptr_width_lp-2:0]      raddr;
    logic [fe_queue_width_lp-1:0] rdata;

    bp_be_fe_queue_ptrs #(
        .els_p(els_p)
    ) ptrs (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .enq_v_i    (fe_in.v),
        .yumi_i     (fe_out.rdy),
        .commit_i   (commit_i),
        .roll_i     (roll_i),
        .clr_i      (clr_i),
        .ready_and_o(fe_in.rdy),
        .enq_o      (enq),
        .v_o        (fe_out.v),
        .empty_o    (empty_o),
        .waddr_o    (waddr),
        .raddr_o    (raddr)
    );

    // Writes are gated by reset so a packet offered then is dropped.
    bsg_mem_1r1w #(
        .width_p               (fe_queue_width_lp),
        .els_p                 (els_p),
        .read_write_same_addr_p(1'b0)
    ) mem (
        .w_clk_i (clk_i),
        .w_v_i   (enq & ~reset_i),
        .w_addr_i(waddr),
        .w_data_i(fe_in.data),
        .r_v_i   (fe_out.v),
        .r_addr_i(raddr),
        .r_data_o(rdata)
    );

    assign fe_out.data = bp_fe_queue_s'(rdata);

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (bp_params_p == e_bp_default_cfg)
                else $error("fe_queue: unsupported config");
            assert (!(fe_in.v && $isunknown(fe_in.data)))
                else $error("fe_queue: unknown packet while valid");
        end
    end
`endif

endmodule

// File: tb/tb_bp_be_fe_queue_buffer.sv
// Randomized bench for the FE queue buffer with a queue-based
// reference model feeding a scoreboard that a monitor drains.
module tb_bp_be_fe_queue_buffer;
    import bp_be_fe_queue_buffer_pkg::*;

    localparam int depth_lp = 8;

    logic clk = 1'b0;
    logic reset_i;
    logic commit_i;
    logic roll_i;
    logic clr_i;
    logic empty_o;

    bp_be_fe_queue_buffer_if fe_in ();
    bp_be_fe_queue_buffer_if fe_out ();

    bp_be_fe_queue_buffer dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .fe_in   (fe_in),
        .fe_out  (fe_out),
        .commit_i(commit_i),
        .roll_i  (roll_i),
        .clr_i   (clr_i),
        .empty_o (empty_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         ready;
        logic         v;
        logic         empty;
        bp_fe_queue_s data;
    } exp_t;

    exp_t         exp_q [$];
    bp_fe_queue_s mq [$];
    int           rd = 0;
    int           checks = 0;
    int           fails = 0;
    logic [38:0]  pcn = 39'h0;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        #3;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("ready_and", 128'(fe_in.rdy), 128'(e.ready));
            check("v_o", 128'(fe_out.v), 128'(e.v));
            check("empty_o", 128'(empty_o), 128'(e.empty));
            if (e.v) begin
                check("fe_queue_o", 128'(fe_out.data), 128'(e.data));
            end
        end
    end

    task automatic cyc(input logic v, input logic [38:0] pc,
                       input logic y, input logic c, input logic r,
                       input logic cl, input logic rs);
        bp_fe_queue_s pkt;
        exp_t         e;
        logic         enq;
        @(negedge clk);
        pkt.msg_type        = e_fe_fetch;
        pkt.pc              = pc;
        pkt.instr           = $urandom;
        pkt.branch_metadata = 12'($urandom);
        y = y && (rd < mq.size());
        if (cl) c = 1'b0;
        else if (r) c = c && (rd >= 1);
        else c = c && ((rd + int'(y)) >= 1);
        fe_in.v    = v;
        fe_in.data = pkt;
        fe_out.rdy = y;
        commit_i   = c;
        roll_i     = r;
        clr_i      = cl;
        reset_i    = rs;
        if (rs) begin
            mq.delete();
            rd = 0;
        end else begin
            e.ready = (mq.size() < depth_lp) && !cl;
            e.v     = rd < mq.size();
            e.empty = !e.v;
            e.data  = e.v ? mq[rd] : pkt;
            exp_q.push_back(e);
            enq = v && e.ready;
            if (cl) begin
                mq.delete();
                rd = 0;
            end else if (r) begin
                if (c) void'(mq.pop_front());
                rd = 0;
            end else begin
                if (y) rd++;
                if (c) begin
                    void'(mq.pop_front());
                    rd--;
                end
            end
            if (enq) mq.push_back(pkt);
        end
    endtask

    task automatic enq_pc();
        cyc(1'b1, 39'h80000000 + pcn, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        pcn += 39'h4;
    endtask

    task automatic idle();
        cyc(1'b0, 39'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        repeat (2 * depth_lp + 2)
            cyc(1'b0, 39'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic summary();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
    endtask

    initial begin
        #500000;
        fails++;
        $display("FAIL watchdog: time limit reached, checks %0d", checks);
        summary();
        $finish;
    end

    initial begin
        fe_in.v    = 1'b0;
        fe_in.data = '0;
        fe_out.rdy = 1'b0;
        commit_i   = 1'b0;
        roll_i     = 1'b0;
        clr_i      = 1'b0;
        reset_i    = 1'b1;
        repeat (2) cyc(1'b0, 39'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle();
        // Fill to full, then offer one more.
        repeat (depth_lp) enq_pc();
        enq_pc();
        repeat (3) cyc(1'b0, 39'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) cyc(1'b1, 39'h80000000 + pcn, 1'b0, 1'b1, 1'b0,
                       1'b0, 1'b0);
        idle();
        drain();
        // Roll back to the oldest uncommitted entry and replay.
        repeat (5) enq_pc();
        repeat (4) cyc(1'b0, 39'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 39'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 39'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 39'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drain();
        // Clear with enqueue and yumi offered.
        repeat (4) enq_pc();
        repeat (2) cyc(1'b0, 39'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 39'h0DEAD00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (2) idle();
        // Depth-1 streaming through several pointer wraps.
        enq_pc();
        repeat (40) begin
            cyc(1'b1, 39'h80000000 + pcn, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            pcn += 39'h4;
        end
        drain();
        // Reset with entries held.
        repeat (5) enq_pc();
        cyc(1'b1, 39'h0BAD000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (2) enq_pc();
        repeat (3) cyc(1'b0, 39'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        // Random traffic.
        repeat (3000) begin
            cyc(($urandom % 4) != 0, 39'($urandom),
                ($urandom % 3) != 0, ($urandom % 3) != 0,
                ($urandom % 23) == 0, ($urandom % 41) == 0,
                ($urandom % 200) == 0);
        end
        drain();
        repeat (3) idle();
        @(negedge clk);
        #5;
        check("scoreboard_drained", 128'(exp_q.size()), 128'(0));
        summary();
        $finish;
    end

endmodule

// File: doc/bp_be_fe_queue_buffer.md
Name: bp_be_fe_queue_buffer

Overview:
Backend-side receiver for the frontend fetch queue. It accepts bp_fe_queue_s packets from the FE over a ready_and handshake and buffers them in a circular queue. The issue stage dequeues them speculatively. Supports commit, roll back to the last committed entry, and full clear on redirect, so the BE can replay or discard fetched instructions without FE involvement. Sits between the FE top's fe_queue output and the BE scheduler.

Parameters:
bp_params_p, e_bp_default_cfg, processor configuration; supplies vaddr/asid/branch metadata widths for fe_queue_width_lp.
els_p, 8, queue depth; power of two, >= 2.
fe_queue_width_lp (localparam), derived, width of bp_fe_queue_s.
ptr_width_lp (localparam), $clog2(els_p)+1, pointer width with wrap bit.

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
fe_queue_i  in  fe_queue_width_lp  packet from FE
fe_queue_v_i  in  1  FE packet valid
fe_queue_ready_and_o  out  1  buffer can accept this cycle
fe_queue_o  out  fe_queue_width_lp  entry at read pointer
fe_queue_v_o  out  1  fe_queue_o valid
fe_queue_yumi_i  in  1  BE consumes fe_queue_o (speculative dequeue)
commit_i  in  1  oldest dequeued entry retired; frees its slot
roll_i  in  1  rewind read pointer to oldest uncommitted entry
clr_i  in  1  discard all entries (redirect)
empty_o  out  1  no unread entries (wptr == rptr)

Behaviour:
- One clock domain; synchronous active-high reset.
- Pointers wptr, rptr, cptr, each ptr_width_lp bits, all reset to 0. Increments wrap modulo 2*els_p; the MSB is the wrap bit.
- Invariant: cptr <= rptr <= wptr in circular order.
- full = (wptr[low] == cptr[low]) & (wptr[msb] != cptr[msb]). Slots are freed only by commit, not by dequeue.
- fe_queue_ready_and_o = ~full & ~clr_i.
- Enqueue fires when fe_queue_v_i & fe_queue_ready_and_o: write to mem[wptr[low]], then wptr++.
- fe_queue_v_o = (rptr != wptr); combinational read of mem[rptr[low]].
- No bypass: a packet enqueued in cycle t is visible on fe_queue_o at t+1 at the earliest.
- fe_queue_yumi_i is legal only when fe_queue_v_o is high; rptr++.
- commit_i is legal only when cptr != rptr, counting a same-cycle yumi (i.e. cptr != rptr_next); cptr++.
- Priority, highest first: reset_i, clr_i, roll_i, normal.
  - clr_i: rptr <= wptr and cptr <= wptr. Same-cycle enqueue is blocked via ready. Same-cycle yumi/commit/roll are ignored.
  - roll_i: rptr <= cptr; yumi is ignored.
  - commit_i in the same cycle as roll_i is honoured: cptr++ and rptr <= cptr+1.
  - Enqueue in the same cycle as roll_i proceeds.
- Simultaneous enqueue and yumi when the queue holds 1 entry: rptr advances, and the new entry appears next cycle, so there is no bubble beyond the no-bypass rule.
- Full with commit in the same cycle: ready stays low that cycle, because ready depends on registered cptr only. The slot is usable next cycle.
- Reset values: fe_queue_ready_and_o=1, fe_queue_v_o=0, empty_o=1. fe_queue_o is don't-care while v=0.
- Storage contents are not reset.
- Reset mid-operation drops all entries; an FE packet presented during reset is not accepted.
- Assertions (sim only):
  - yumi without v.
  - commit with cptr==rptr_next.
  - fe_queue_i X when v.

Decomposition:
- No new package types. bp_fe_queue_s comes from the existing core interface declare macro (bp_common_pkg).
- Storage: bsg_mem_1r1w, width fe_queue_width_lp, els_p, read_write_same_addr_p=0.
- One natural sub-module: bp_be_fe_queue_ptrs. It holds the three pointer registers, full/empty logic and the priority muxing. The top module is storage plus handshake glue.

Test Plan:
- Reset, then enqueue pc=0x8000_0000..0x8000_001C (8 pkts, els_p=8) with no yumi → ready drops after the 8th accept; v_o=1 with pc 0x8000_0000.
- Dequeue 3, then commit 3 → entries 0x..0C onward are readable. Ready rises the cycle after the first commit, not the same cycle.
- Enqueue 5, yumi 4, commit 1, roll → fe_queue_o returns entry #2. The next 3 yumis replay #2, #3, #4 in order.
- Enqueue 4, yumi 2, assert clr_i with v_i and yumi high → ready_and_o=0 that cycle. Next cycle v_o=0, empty_o=1, and the packet offered during clr is not stored.
- Back-to-back streaming for 40 cycles, enqueue+yumi+commit every cycle with depth 1 → no overflow, pointer wrap exercised 2.5×, order preserved.
- Assert reset_i mid-stream with 5 entries held → next cycle v_o=0, ready_and_o=1, empty_o=1. Subsequent enqueue reads back correctly.
